// File: rtl/shifter8_seq.sv
// shifter8_seq: multi-cycle 8-bit shift engine, one bit position per clock.
// Takes one command over a valid/ready input handshake and holds the result
// on a valid/ready output port until the consumer takes it.
// Optional feature: define SHIFTER8_CARRY_EN to add a 'carry' output. It
// carries the last bit shifted or rotated out of the operand.
module shifter8_seq #(
   parameter int AMT_W = 3
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [AMT_W-1:0] amt,
   input  logic [7:0]       din,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       dout,
   output logic             busy
`ifdef SHIFTER8_CARRY_EN
   ,
   output logic             carry
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic [2:0] OP_PASS = 3'b000;
   localparam logic [2:0] OP_LSL  = 3'b001;
   localparam logic [2:0] OP_LSR  = 3'b010;
   localparam logic [2:0] OP_ASR  = 3'b011;
   localparam logic [2:0] OP_ROL  = 3'b100;
   localparam logic [2:0] OP_ROR  = 3'b101;

   state_t           state_q, state_d;
   logic [7:0]       work_q, work_d;
   logic [AMT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       op_q, op_d;
`ifdef SHIFTER8_CARRY_EN
   logic             carry_q, carry_d;
`endif

   // PASS and the two reserved codes leave the operand untouched, so a
   // command using them skips the SHIFT state entirely.
   function automatic logic is_pass_class(input logic [2:0] code);
      return (code == OP_PASS) || (code[2:1] == 2'b11);
   endfunction

   // Apply one single-bit step of the given operation.
   function automatic logic [7:0] step(input logic [2:0] code, input logic [7:0] v);
      logic [7:0] r;
      r = v;
      case (code)
         OP_LSL:  r = {v[6:0], 1'b0};
         OP_LSR:  r = {1'b0, v[7:1]};
         OP_ASR:  r = {v[7], v[7:1]};
         OP_ROL:  r = {v[6:0], v[7]};
         OP_ROR:  r = {v[0], v[7:1]};
         default: r = v;
      endcase
      return r;
   endfunction

`ifdef SHIFTER8_CARRY_EN
   // The bit that leaves the operand during one step of the operation.
   function automatic logic step_out(input logic [2:0] code, input logic [7:0] v);
      logic b;
      b = 1'b0;
      case (code)
         OP_LSL, OP_ROL:         b = v[7];
         OP_LSR, OP_ASR, OP_ROR: b = v[0];
         default:                b = 1'b0;
      endcase
      return b;
   endfunction
`endif

   // Next-state and datapath update for the IDLE -> SHIFT -> DONE sequence.
   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
`ifdef SHIFTER8_CARRY_EN
      carry_d = carry_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               work_d = din;
               op_d   = op;
               cnt_d  = amt;
`ifdef SHIFTER8_CARRY_EN
               carry_d = 1'b0;
`endif
               if ((amt != '0) && !is_pass_class(op)) begin
                  state_d = ST_SHIFT;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_SHIFT: begin
            work_d = step(op_q, work_q);
            cnt_d  = cnt_q - AMT_W'(1);
`ifdef SHIFTER8_CARRY_EN
            carry_d = step_out(op_q, work_q);
`endif
            if (cnt_q == AMT_W'(1)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; the synchronous reset discards any command in flight.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         work_q  <= 8'h00;
         cnt_q   <= '0;
         op_q    <= 3'b000;
`ifdef SHIFTER8_CARRY_EN
         carry_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
`ifdef SHIFTER8_CARRY_EN
         carry_q <= carry_d;
`endif
      end
   end

   // Outputs decode straight from registers, so they are glitch-free.
   always_comb begin
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q == ST_DONE);
      busy      = (state_q != ST_IDLE);
      dout      = work_q;
`ifdef SHIFTER8_CARRY_EN
      carry     = carry_q;
`endif
   end

endmodule

// File: tb/tb_shifter8_seq.sv
// tb_shifter8_seq: self-checking bench for shifter8_seq.
// The expected results come from a whole-shift arithmetic model of each
// operation. Define SHIFTER8_CARRY_EN to build and check the carry port as well.
module tb_shifter8_seq;

   logic       clk;
   logic       reset_n;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] op;
   logic [2:0] amt;
   logic [7:0] din;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] dout;
   logic       busy;
`ifdef SHIFTER8_CARRY_EN
   logic       carry;
`endif

   int checks;
   int passes;

   shifter8_seq #(.AMT_W(3)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .amt       (amt),
      .din       (din),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .dout      (dout),
      .busy      (busy)
`ifdef SHIFTER8_CARRY_EN
      ,
      .carry     (carry)
`endif
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: computes the whole multi-bit shift in one step.
   function automatic logic is_pass(input logic [2:0] o, input int a);
      return (o == 3'd0) || (o == 3'd6) || (o == 3'd7) || (a == 0);
   endfunction

   function automatic logic [7:0] model_dout(input logic [2:0] o, input int a, input logic [7:0] d);
      int v;
      int s;
      v = int'(d);
      if (is_pass(o, a)) return d;
      case (o)
         3'd1: return 8'((v << a) & 255);
         3'd2: return 8'(v >> a);
         3'd3: begin
            s = (v >= 128) ? v - 256 : v;
            return 8'((s >>> a) & 255);
         end
         3'd4: return 8'(((v << a) | (v >> (8 - a))) & 255);
         3'd5: return 8'(((v >> a) | (v << (8 - a))) & 255);
         default: return d;
      endcase
   endfunction

   function automatic logic model_carry(input logic [2:0] o, input int a, input logic [7:0] d);
      int v;
      v = int'(d);
      if (is_pass(o, a)) return 1'b0;
      case (o)
         3'd1, 3'd4: return 1'((v >> (8 - a)) & 1);
         default:    return 1'((v >> (a - 1)) & 1);
      endcase
   endfunction

   function automatic int model_latency(input logic [2:0] o, input int a);
      return is_pass(o, a) ? 1 : 1 + a;
   endfunction

   // Drive one command, measure latency, hold back the result for 'hold' cycles, then complete the handshake.
   task automatic applyStimulus(input logic [2:0] o, input logic [2:0] a, input logic [7:0] d,
                                input int hold,
                                output int lat, output logic [7:0] d_obs, output logic c_obs,
                                output logic b_obs, output logic stable,
                                output logic post_in_ready, output logic post_out_valid);
      int wait_cnt;
      wait_cnt = 0;
      while (!in_ready && wait_cnt < 20) begin
         @(negedge clk);
         wait_cnt++;
      end
      op       = o;
      amt      = a;
      din      = d;
      in_valid = 1'b1;
      @(posedge clk);
      lat = 0;
      while (lat < 20) begin
         @(negedge clk);
         if (lat == 0) in_valid = 1'b0;
         lat++;
         if (out_valid) break;
      end
      if (!out_valid) lat = -1;
      d_obs = dout;
      b_obs = busy;
`ifdef SHIFTER8_CARRY_EN
      c_obs = carry;
`else
      c_obs = 1'b0;
`endif
      stable = 1'b1;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         if (!out_valid || dout !== d_obs) stable = 1'b0;
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready      = 1'b0;
      post_in_ready  = in_ready;
      post_out_valid = out_valid;
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      op        = 3'd0;
      amt       = 3'd0;
      din       = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid, busy, dout} !== {1'b1, 1'b0, 1'b0, 8'h00})
         $display("[TB] FAIL reset_state got rdy/vld/busy/dout=%b%b%b/%h exp 100/00", in_ready, out_valid, busy, dout);
      else passes++;
`ifdef SHIFTER8_CARRY_EN
      checks++;
      if (carry !== 1'b0) $display("[TB] FAIL reset_carry got %b exp 0", carry);
      else passes++;
`endif
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_shift();
      op = 3'd1; amt = 3'd5; din = 8'h01; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) $display("[TB] FAIL mid_shift_busy got %b exp 1", busy);
      else passes++;
      reset_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid, busy, dout} !== {1'b1, 1'b0, 1'b0, 8'h00})
         $display("[TB] FAIL mid_shift_reset got rdy/vld/busy/dout=%b%b%b/%h exp 100/00", in_ready, out_valid, busy, dout);
      else passes++;
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_lsl_backpressure();
      int lat; logic [7:0] d_obs; logic c_obs, b_obs, stable, pir, pov;
      applyStimulus(3'd1, 3'd3, 8'h81, 3, lat, d_obs, c_obs, b_obs, stable, pir, pov);
      checks++;
      if (lat !== 4) $display("[TB] FAIL lsl_latency got %0d exp 4", lat); else passes++;
      checks++;
      if (d_obs !== 8'h08) $display("[TB] FAIL lsl_dout got %h exp 08", d_obs); else passes++;
      checks++;
      if (stable !== 1'b1) $display("[TB] FAIL lsl_hold_stable got %b exp 1", stable); else passes++;
      checks++;
      if ({pir, pov} !== 2'b10) $display("[TB] FAIL lsl_post_handshake got rdy/vld=%b%b exp 10", pir, pov); else passes++;
`ifdef SHIFTER8_CARRY_EN
      checks++;
      if (c_obs !== 1'b0) $display("[TB] FAIL lsl_carry got %b exp 0", c_obs); else passes++;
`endif
   endtask

   task automatic test_asr_lsr();
      int lat; logic [7:0] d_obs; logic c_obs, b_obs, stable, pir, pov;
      applyStimulus(3'd3, 3'd2, 8'h90, 0, lat, d_obs, c_obs, b_obs, stable, pir, pov);
      checks++;
      if (d_obs !== 8'hE4) $display("[TB] FAIL asr_dout got %h exp e4", d_obs); else passes++;
      applyStimulus(3'd2, 3'd2, 8'h90, 0, lat, d_obs, c_obs, b_obs, stable, pir, pov);
      checks++;
      if (d_obs !== 8'h24) $display("[TB] FAIL lsr_dout got %h exp 24", d_obs); else passes++;
   endtask

   task automatic test_rotate();
      int lat; logic [7:0] d_obs; logic c_obs, b_obs, stable, pir, pov;
      applyStimulus(3'd4, 3'd7, 8'hA5, 1, lat, d_obs, c_obs, b_obs, stable, pir, pov);
      checks++;
      if (d_obs !== 8'hD2) $display("[TB] FAIL rol7_dout got %h exp d2", d_obs); else passes++;
      checks++;
      if (lat !== 8) $display("[TB] FAIL rol7_latency got %0d exp 8", lat); else passes++;
      applyStimulus(3'd5, 3'd1, 8'hA5, 0, lat, d_obs, c_obs, b_obs, stable, pir, pov);
      checks++;
      if (d_obs !== 8'hD2) $display("[TB] FAIL ror1_dout got %h exp d2", d_obs); else passes++;
`ifdef SHIFTER8_CARRY_EN
      checks++;
      if (c_obs !== 1'b1) $display("[TB] FAIL ror1_carry got %b exp 1", c_obs); else passes++;
`endif
   endtask

   task automatic test_boundary();
      int lat; logic [7:0] d_obs; logic c_obs, b_obs, stable, pir, pov;
      applyStimulus(3'd1, 3'd7, 8'hFF, 0, lat, d_obs, c_obs, b_obs, stable, pir, pov);
      checks++;
      if (d_obs !== 8'h80) $display("[TB] FAIL lsl7_dout got %h exp 80", d_obs); else passes++;
      applyStimulus(3'd4, 3'd0, 8'h5B, 0, lat, d_obs, c_obs, b_obs, stable, pir, pov);
      checks++;
      if ({lat, d_obs} !== {32'd1, 8'h5B}) $display("[TB] FAIL rol0 got lat/dout=%0d/%h exp 1/5b", lat, d_obs); else passes++;
   endtask

   task automatic test_pass_reserved();
      int lat; logic [7:0] d_obs; logic c_obs, b_obs, stable, pir, pov;
      applyStimulus(3'd6, 3'd6, 8'h3C, 0, lat, d_obs, c_obs, b_obs, stable, pir, pov);
      checks++;
      if ({lat, d_obs} !== {32'd1, 8'h3C}) $display("[TB] FAIL reserved_pass got lat/dout=%0d/%h exp 1/3c", lat, d_obs); else passes++;
`ifdef SHIFTER8_CARRY_EN
      checks++;
      if (c_obs !== 1'b0) $display("[TB] FAIL reserved_carry got %b exp 0", c_obs); else passes++;
`endif
   endtask

   task automatic test_busy_reject();
      int n;
      op = 3'd1; amt = 3'd4; din = 8'h11; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      op = 3'd0; amt = 3'd0; din = 8'hFF;
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if ({out_valid, dout} !== {1'b1, 8'h10}) $display("[TB] FAIL busy_first_result got vld/dout=%b/%h exp 1/10", out_valid, dout); else passes++;
      repeat (2) @(negedge clk);
      checks++;
      if ({out_valid, dout} !== {1'b1, 8'h10}) $display("[TB] FAIL busy_first_hold got vld/dout=%b/%h exp 1/10", out_valid, dout); else passes++;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if ({in_ready, out_valid} !== 2'b10) $display("[TB] FAIL busy_after_handshake got rdy/vld=%b%b exp 10", in_ready, out_valid); else passes++;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if ({out_valid, dout} !== {1'b1, 8'hFF}) $display("[TB] FAIL busy_second_result got vld/dout=%b/%h exp 1/ff", out_valid, dout); else passes++;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_random();
      int lat; logic [7:0] d_obs; logic c_obs, b_obs, stable, pir, pov;
      logic [2:0] o, a; logic [7:0] d; int hold;
      for (int i = 0; i < 40; i++) begin
         o    = 3'($urandom_range(0, 7));
         a    = 3'($urandom_range(0, 7));
         d    = 8'($urandom);
         hold = int'($urandom_range(0, 2));
         applyStimulus(o, a, d, hold, lat, d_obs, c_obs, b_obs, stable, pir, pov);
         checks++;
         if (d_obs !== model_dout(o, int'(a), d) || lat != model_latency(o, int'(a)) || !stable || !b_obs || pir !== 1'b1 || pov !== 1'b0)
            $display("[TB] FAIL random_%0d op=%0d amt=%0d din=%h got dout/lat/stable/busy=%h/%0d/%b/%b exp %h/%0d/1/1",
                     i, o, a, d, d_obs, lat, stable, b_obs, model_dout(o, int'(a), d), model_latency(o, int'(a)));
         else passes++;
`ifdef SHIFTER8_CARRY_EN
         checks++;
         if (c_obs !== model_carry(o, int'(a), d))
            $display("[TB] FAIL random_carry_%0d got %b exp %b", i, c_obs, model_carry(o, int'(a), d));
         else passes++;
`endif
      end
   endtask

   // Run the scenarios in order, then print the summary.
   initial begin
      checks = 0;
      passes = 0;
      test_reset();
      test_reset_mid_shift();
      test_lsl_backpressure();
      test_asr_lsr();
      test_rotate();
      test_boundary();
      test_pass_reserved();
      test_busy_reject();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
